// File: rtl/rx_merge.sv
// rx_merge: two 8-deep lane FIFOs merged into one 16-deep output FIFO under a sequencing FSM.
// Build option RX_ROUND_ROBIN_EN: round-robin lane arbitration (default build: lane 0 wins ties).
module rx_merge (
   input  logic       clk,
   input  logic       RESET,
   input  logic       PUSH_D0,
   input  logic       PUSH_D1,
   input  logic [5:0] DATA_D0,
   input  logic [5:0] DATA_D1,
   input  logic       init,
   input  logic [4:0] D0_low,
   input  logic [4:0] D0_high,
   input  logic [4:0] D1_low,
   input  logic [4:0] D1_high,
   input  logic [4:0] OUT_low,
   input  logic [4:0] OUT_high,
   input  logic       POP_OUT,
   output logic       PAUSE_D0,
   output logic       PAUSE_D1,
   output logic [5:0] DATA_OUT,
   output logic       VALID_OUT,
   output logic       EMPTY_OUT,
   output logic       ALMOST_EMPTY_OUT,
   output logic       ERR,
   output logic [2:0] state
);

   // state  | meaning
   // RESET  | held in reset; first edge after release enters INIT
   // INIT   | thresholds load while init=1; lanes ignored
   // IDLE   | all FIFOs empty, waiting for traffic
   // ACTIVE | at least one FIFO holds data
   // ERROR  | sticky overflow/underflow seen; FIFOs keep running until reset
   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

   state_t     state_q, state_d;

   logic [5:0] lane0_mem_q [8];
   logic [5:0] lane1_mem_q [8];
   logic [5:0] out_mem_q   [16];

   logic [2:0] wr0_ptr_q, wr0_ptr_d, rd0_ptr_q, rd0_ptr_d;
   logic [2:0] wr1_ptr_q, wr1_ptr_d, rd1_ptr_q, rd1_ptr_d;
   logic [3:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
   logic [3:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
   logic [4:0] out_cnt_q, out_cnt_d;

   logic [5:0] data_out_q, data_out_d;
   logic       valid_q, valid_d;
   logic       err_q, err_d;

   logic [4:0] d0_low_q, d0_low_d, d0_high_q, d0_high_d;
   logic [4:0] d1_low_q, d1_low_d, d1_high_q, d1_high_d;
   logic [4:0] out_low_q, out_low_d, out_high_q, out_high_d;

   logic       run, any_ne, elig0, elig1, xfer0, xfer1;
   logic       wr0, wr1, ovf0, ovf1, pop_ok, unf;
   logic [5:0] xfer_data;

`ifdef RX_ROUND_ROBIN_EN
   logic       last1_q, last1_d;
`endif

   // Low thresholds of the lanes and the high threshold of the output are held for software only.
   logic       unused_thr;
   assign unused_thr = ^{d0_low_q, d1_low_q, out_high_q};

   always_comb begin
      run    = (state_q == ST_IDLE) || (state_q == ST_ACTIVE) || (state_q == ST_ERROR);
      any_ne = (cnt0_q != 4'd0) || (cnt1_q != 4'd0) || (out_cnt_q != 5'd0);
      elig0  = run && (cnt0_q != 4'd0) && (out_cnt_q != 5'd16);
      elig1  = run && (cnt1_q != 4'd0) && (out_cnt_q != 5'd16);

`ifdef RX_ROUND_ROBIN_EN
      if (elig0 && elig1) begin
         xfer0 = last1_q;
         xfer1 = !last1_q;
      end else begin
         xfer0 = elig0;
         xfer1 = elig1;
      end
      last1_d = last1_q;
      if (xfer0)
         last1_d = 1'b0;
      else if (xfer1)
         last1_d = 1'b1;
`else
      xfer0 = elig0;
      xfer1 = elig1 && !elig0;
`endif

      xfer_data = xfer0 ? lane0_mem_q[rd0_ptr_q] : lane1_mem_q[rd1_ptr_q];

      // A full lane drained on the same edge still has room for the incoming word.
      wr0  = run && PUSH_D0 && ((cnt0_q != 4'd8) || xfer0);
      ovf0 = run && PUSH_D0 && (cnt0_q == 4'd8) && !xfer0;
      wr1  = run && PUSH_D1 && ((cnt1_q != 4'd8) || xfer1);
      ovf1 = run && PUSH_D1 && (cnt1_q == 4'd8) && !xfer1;

      pop_ok = POP_OUT && (out_cnt_q != 5'd0);
      unf    = POP_OUT && (out_cnt_q == 5'd0);

      wr0_ptr_d = wr0   ? wr0_ptr_q + 3'd1 : wr0_ptr_q;
      rd0_ptr_d = xfer0 ? rd0_ptr_q + 3'd1 : rd0_ptr_q;
      cnt0_d    = cnt0_q + {3'd0, wr0} - {3'd0, xfer0};
      wr1_ptr_d = wr1   ? wr1_ptr_q + 3'd1 : wr1_ptr_q;
      rd1_ptr_d = xfer1 ? rd1_ptr_q + 3'd1 : rd1_ptr_q;
      cnt1_d    = cnt1_q + {3'd0, wr1} - {3'd0, xfer1};

      out_wr_d  = (xfer0 || xfer1) ? out_wr_q + 4'd1 : out_wr_q;
      out_rd_d  = pop_ok ? out_rd_q + 4'd1 : out_rd_q;
      out_cnt_d = out_cnt_q + {4'd0, (xfer0 || xfer1)} - {4'd0, pop_ok};

      data_out_d = pop_ok ? out_mem_q[out_rd_q] : data_out_q;
      valid_d    = pop_ok;
      err_d      = err_q | ovf0 | ovf1 | unf;

      d0_low_d   = d0_low_q;
      d0_high_d  = d0_high_q;
      d1_low_d   = d1_low_q;
      d1_high_d  = d1_high_q;
      out_low_d  = out_low_q;
      out_high_d = out_high_q;
      if ((state_q == ST_INIT) && init) begin
         d0_low_d   = D0_low;
         d0_high_d  = D0_high;
         d1_low_d   = D1_low;
         d1_high_d  = D1_high;
         out_low_d  = OUT_low;
         out_high_d = OUT_high;
      end

      state_d = state_q;
      case (state_q)
         ST_RESET:  state_d = ST_INIT;
         ST_INIT: begin
            if (err_q)
               state_d = ST_ERROR;
            else if (!init)
               state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (err_q)
               state_d = ST_ERROR;
            else if (init)
               state_d = ST_INIT;
            else if (any_ne)
               state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (err_q)
               state_d = ST_ERROR;
            else if (!any_ne)
               state_d = ST_IDLE;
         end
         ST_ERROR:  state_d = ST_ERROR;
         default:   state_d = ST_RESET;
      endcase
   end

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state_q    <= ST_RESET;
         wr0_ptr_q  <= '0;
         rd0_ptr_q  <= '0;
         cnt0_q     <= '0;
         wr1_ptr_q  <= '0;
         rd1_ptr_q  <= '0;
         cnt1_q     <= '0;
         out_wr_q   <= '0;
         out_rd_q   <= '0;
         out_cnt_q  <= '0;
         data_out_q <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         d0_low_q   <= '0;
         d0_high_q  <= '0;
         d1_low_q   <= '0;
         d1_high_q  <= '0;
         out_low_q  <= '0;
         out_high_q <= '0;
`ifdef RX_ROUND_ROBIN_EN
         last1_q    <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         wr0_ptr_q  <= wr0_ptr_d;
         rd0_ptr_q  <= rd0_ptr_d;
         cnt0_q     <= cnt0_d;
         wr1_ptr_q  <= wr1_ptr_d;
         rd1_ptr_q  <= rd1_ptr_d;
         cnt1_q     <= cnt1_d;
         out_wr_q   <= out_wr_d;
         out_rd_q   <= out_rd_d;
         out_cnt_q  <= out_cnt_d;
         data_out_q <= data_out_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         d0_low_q   <= d0_low_d;
         d0_high_q  <= d0_high_d;
         d1_low_q   <= d1_low_d;
         d1_high_q  <= d1_high_d;
         out_low_q  <= out_low_d;
         out_high_q <= out_high_d;
`ifdef RX_ROUND_ROBIN_EN
         last1_q    <= last1_d;
`endif
      end
   end

   // Storage arrays carry no reset; pointers and counts define what is valid.
   always_ff @(posedge clk) begin
      if (wr0)
         lane0_mem_q[wr0_ptr_q] <= DATA_D0;
      if (wr1)
         lane1_mem_q[wr1_ptr_q] <= DATA_D1;
      if (xfer0 || xfer1)
         out_mem_q[out_wr_q] <= xfer_data;
   end

   assign PAUSE_D0         = ({1'b0, cnt0_q} >= d0_high_q);
   assign PAUSE_D1         = ({1'b0, cnt1_q} >= d1_high_q);
   assign EMPTY_OUT        = (out_cnt_q == 5'd0);
   assign ALMOST_EMPTY_OUT = (out_cnt_q <= out_low_q);
   assign DATA_OUT         = data_out_q;
   assign VALID_OUT        = valid_q;
   assign ERR              = err_q;
   assign state            = state_q;

endmodule

// File: tb/tb_rx_merge.sv
// Self-checking bench for rx_merge: vector table, directed corner sequences and a queue-based model.
`timescale 1ns/1ps
module tb_rx_merge;
   localparam int S_RESET = 0, S_INIT = 1, S_IDLE = 2, S_ACTIVE = 3, S_ERROR = 4;
`ifdef RX_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic       clk;
   logic       RESET;
   logic       PUSH_D0, PUSH_D1;
   logic [5:0] DATA_D0, DATA_D1;
   logic       init;
   logic [4:0] D0_low, D0_high, D1_low, D1_high, OUT_low, OUT_high;
   logic       POP_OUT;
   logic       PAUSE_D0, PAUSE_D1;
   logic [5:0] DATA_OUT;
   logic       VALID_OUT, EMPTY_OUT, ALMOST_EMPTY_OUT, ERR;
   logic [2:0] state;

   rx_merge dut (
      .clk(clk), .RESET(RESET),
      .PUSH_D0(PUSH_D0), .PUSH_D1(PUSH_D1),
      .DATA_D0(DATA_D0), .DATA_D1(DATA_D1),
      .init(init),
      .D0_low(D0_low), .D0_high(D0_high), .D1_low(D1_low), .D1_high(D1_high),
      .OUT_low(OUT_low), .OUT_high(OUT_high),
      .POP_OUT(POP_OUT),
      .PAUSE_D0(PAUSE_D0), .PAUSE_D1(PAUSE_D1),
      .DATA_OUT(DATA_OUT), .VALID_OUT(VALID_OUT),
      .EMPTY_OUT(EMPTY_OUT), .ALMOST_EMPTY_OUT(ALMOST_EMPTY_OUT),
      .ERR(ERR), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFOs are plain queues, rules applied in edge order.
   logic [5:0] m_l0 [$];
   logic [5:0] m_l1 [$];
   logic [5:0] m_out [$];
   int         m_state;
   bit         m_err, m_valid, m_last1;
   logic [5:0] m_dout;
   logic [4:0] m_d0h, m_d1h, m_outl;

   task automatic model_reset();
      m_l0.delete(); m_l1.delete(); m_out.delete();
      m_state = S_RESET; m_err = 0; m_valid = 0; m_dout = '0;
      m_d0h = '0; m_d1h = '0; m_outl = '0; m_last1 = 1;
   endtask

   task automatic model_edge();
      bit run, pre_any, flag;
      int grant;
      run     = (m_state >= S_IDLE);
      pre_any = (m_l0.size() + m_l1.size() + m_out.size()) != 0;
      flag    = 0;
      grant   = -1;
      if (run && m_out.size() < 16) begin
         if (m_l0.size() != 0 && m_l1.size() != 0)
            grant = (RR && !m_last1) ? 1 : 0;
         else if (m_l0.size() != 0)
            grant = 0;
         else if (m_l1.size() != 0)
            grant = 1;
      end
      if (POP_OUT) begin
         if (m_out.size() != 0) begin
            m_dout  = m_out.pop_front();
            m_valid = 1;
         end else begin
            m_valid = 0;
            flag    = 1;
         end
      end else
         m_valid = 0;
      if (grant == 0) m_out.push_back(m_l0.pop_front());
      if (grant == 1) m_out.push_back(m_l1.pop_front());
      if (grant >= 0) m_last1 = (grant == 1);
      if (run && PUSH_D0) begin
         if (m_l0.size() < 8) m_l0.push_back(DATA_D0); else flag = 1;
      end
      if (run && PUSH_D1) begin
         if (m_l1.size() < 8) m_l1.push_back(DATA_D1); else flag = 1;
      end
      case (m_state)
         S_RESET: m_state = S_INIT;
         S_INIT: begin
            if (init) begin m_d0h = D0_high; m_d1h = D1_high; m_outl = OUT_low; end
            if (m_err) m_state = S_ERROR; else if (!init) m_state = S_IDLE;
         end
         S_IDLE: begin
            if (m_err) m_state = S_ERROR;
            else if (init) m_state = S_INIT;
            else if (pre_any) m_state = S_ACTIVE;
         end
         S_ACTIVE: begin
            if (m_err) m_state = S_ERROR; else if (!pre_any) m_state = S_IDLE;
         end
         default: m_state = S_ERROR;
      endcase
      m_err = m_err | flag;
   endtask

   task automatic check_all();
      chk("state", state, m_state);
      chk("ERR", ERR, m_err);
      chk("VALID_OUT", VALID_OUT, m_valid);
      chk("DATA_OUT", DATA_OUT, m_dout);
      chk("EMPTY_OUT", EMPTY_OUT, m_out.size() == 0);
      chk("ALMOST_EMPTY_OUT", ALMOST_EMPTY_OUT, m_out.size() <= int'(m_outl));
      chk("PAUSE_D0", PAUSE_D0, m_l0.size() >= int'(m_d0h));
      chk("PAUSE_D1", PAUSE_D1, m_l1.size() >= int'(m_d1h));
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      PUSH_D0 = 0; PUSH_D1 = 0; DATA_D0 = '0; DATA_D1 = '0; POP_OUT = 0; init = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      RESET = 1;
      model_reset();
      repeat (2) @(posedge clk);
      #1 RESET = 0;
   endtask

   task automatic init_seq(input logic [4:0] d0h, input logic [4:0] d1h, input logic [4:0] outl);
      D0_low = 5'd1; D0_high = d0h; D1_low = 5'd1; D1_high = d1h; OUT_low = outl; OUT_high = 5'd14;
      init = 1; tick(); tick();
      init = 0; tick();
   endtask

   typedef struct {
      bit         init;
      bit         push0;
      logic [5:0] d0;
      bit         pop;
      bit         e_valid;
      logic [5:0] e_data;
      bit         e_empty;
      bit         e_ae;
      bit         e_pause0;
      logic [2:0] e_state;
   } vec_t;

   vec_t       tbl [7];
   logic [5:0] exp_order [8];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{1, 0, 6'd0,  0, 0, 6'd0,  1, 1, 1, 3'd1};
      tbl[1] = '{1, 0, 6'd0,  0, 0, 6'd0,  1, 1, 0, 3'd1};
      tbl[2] = '{0, 0, 6'd0,  0, 0, 6'd0,  1, 1, 0, 3'd2};
      tbl[3] = '{0, 1, 6'h2A, 0, 0, 6'd0,  1, 1, 0, 3'd2};
      tbl[4] = '{0, 0, 6'd0,  0, 0, 6'd0,  0, 1, 0, 3'd3};
      tbl[5] = '{0, 0, 6'd0,  1, 1, 6'h2A, 1, 1, 0, 3'd3};
      tbl[6] = '{0, 0, 6'd0,  0, 0, 6'h2A, 1, 1, 0, 3'd2};
      for (int k = 0; k < 4; k++) begin
         if (RR) begin
            exp_order[2*k]   = 6'(8'h10 + k);
            exp_order[2*k+1] = 6'(8'h20 + k);
         end else begin
            exp_order[k]     = 6'(8'h10 + k);
            exp_order[k+4]   = 6'(8'h20 + k);
         end
      end

      // reset values
      D0_low = 5'd1; D0_high = 5'd3; D1_low = 5'd1; D1_high = 5'd3; OUT_low = 5'd1; OUT_high = 5'd14;
      do_reset();
      chk("rst_state", state, 0);
      chk("rst_EMPTY_OUT", EMPTY_OUT, 1);
      chk("rst_ALMOST_EMPTY_OUT", ALMOST_EMPTY_OUT, 1);
      chk("rst_PAUSE_D0", PAUSE_D0, 1);
      chk("rst_PAUSE_D1", PAUSE_D1, 1);
      chk("rst_ERR", ERR, 0);
      chk("rst_VALID_OUT", VALID_OUT, 0);
      chk("rst_DATA_OUT", DATA_OUT, 0);

      // threshold load and single-word round trip
      for (int i = 0; i < 7; i++) begin
         init = tbl[i].init; PUSH_D0 = tbl[i].push0; DATA_D0 = tbl[i].d0; POP_OUT = tbl[i].pop;
         tick();
         chk($sformatf("row%0d_VALID_OUT", i), VALID_OUT, tbl[i].e_valid);
         chk($sformatf("row%0d_DATA_OUT", i), DATA_OUT, tbl[i].e_data);
         chk($sformatf("row%0d_EMPTY_OUT", i), EMPTY_OUT, tbl[i].e_empty);
         chk($sformatf("row%0d_ALMOST_EMPTY", i), ALMOST_EMPTY_OUT, tbl[i].e_ae);
         chk($sformatf("row%0d_PAUSE_D0", i), PAUSE_D0, tbl[i].e_pause0);
         chk($sformatf("row%0d_state", i), state, tbl[i].e_state);
      end
      idle_inputs();

      // both lanes push on the same cycles; arbitration decides the merge order
      for (int k = 0; k < 4; k++) begin
         PUSH_D0 = 1; DATA_D0 = 6'(8'h10 + k);
         PUSH_D1 = 1; DATA_D1 = 6'(8'h20 + k);
         tick();
      end
      idle_inputs();
      repeat (6) tick();
      for (int k = 0; k < 8; k++) begin
         POP_OUT = 1;
         tick();
         chk($sformatf("order%0d_valid", k), VALID_OUT, 1);
         chk($sformatf("order%0d_data", k), DATA_OUT, exp_order[k]);
      end
      POP_OUT = 0;
      tick();

      // lane 0 overflow while the output FIFO is full
      do_reset();
      init_seq(5'd3, 5'd3, 5'd1);
      for (int k = 0; k < 16; k++) begin
         PUSH_D1 = 1; DATA_D1 = 6'(k);
         tick();
      end
      idle_inputs();
      repeat (2) tick();
      chk("outfull_almost_empty", ALMOST_EMPTY_OUT, 0);
      for (int k = 1; k <= 9; k++) begin
         PUSH_D0 = 1; DATA_D0 = 6'(8'h2F + k);
         tick();
         if (k == 2) chk("pause0_at_2", PAUSE_D0, 0);
         if (k == 3) chk("pause0_at_3", PAUSE_D0, 1);
         if (k == 8) chk("err_before_ovf", ERR, 0);
         if (k == 9) chk("err_after_ovf", ERR, 1);
      end
      idle_inputs();
      tick();
      chk("state_error", state, 4);
      for (int k = 0; k < 24; k++) begin
         POP_OUT = 1;
         tick();
      end
      chk("drain_last_word", DATA_OUT, 6'h37);
      tick();
      chk("drain_dropped_valid", VALID_OUT, 0);
      idle_inputs();

      // underflow, then asynchronous reset in the middle of traffic
      do_reset();
      init_seq(5'd3, 5'd3, 5'd1);
      POP_OUT = 1;
      tick();
      chk("unf_valid", VALID_OUT, 0);
      chk("unf_err", ERR, 1);
      POP_OUT = 0;
      for (int k = 0; k < 2; k++) begin
         PUSH_D0 = 1; DATA_D0 = 6'(k + 5);
         tick();
      end
      idle_inputs();
      RESET = 1;
      #2;
      chk("async_rst_err", ERR, 0);
      chk("async_rst_empty", EMPTY_OUT, 1);
      chk("async_rst_state", state, 0);
      chk("async_rst_pause0", PAUSE_D0, 1);
      do_reset();
      check_all();

      // randomized traffic against the model
      for (int ep = 0; ep < 4; ep++) begin
         int p_push, p_pop;
         do_reset();
         init_seq(5'($urandom_range(0, 10)), 5'($urandom_range(0, 10)), 5'($urandom_range(0, 17)));
         p_push = (ep == 1) ? 70 : 35;
         p_pop  = (ep == 1) ? 30 : 80;
         for (int c = 0; c < 400; c++) begin
            PUSH_D0 = ($urandom_range(0, 99) < p_push);
            PUSH_D1 = ($urandom_range(0, 99) < p_push);
            DATA_D0 = 6'($urandom);
            DATA_D1 = 6'($urandom);
            if (ep < 2)
               POP_OUT = (m_out.size() != 0) && ($urandom_range(0, 99) < p_pop);
            else
               POP_OUT = ($urandom_range(0, 99) < 40);
            init = ($urandom_range(0, 99) < 3);
            tick();
         end
         idle_inputs();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
